// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath stages: FSM state encoding
// for the max-reduction sequencer and FP32 constants.
package softmax_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fp32_gt_cmp.sv
// Combinational FP32 "a strictly greater than b" comparator.
// Uses sign-magnitude ordering with +0 and -0 treated as equal.
// NaN operands are not handled and give an arbitrary but defined result.
module fp32_gt_cmp
  import softmax_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              a_gt_b
);

  logic bothZero;

  // Order by sign first, then by magnitude (reversed when both are negative)
  always_comb begin
    bothZero = (a[FP32_W-2:0] == '0) && (b[FP32_W-2:0] == '0);
    a_gt_b   = 1'b0;
    if (bothZero) begin
      a_gt_b = 1'b0;
    end else if (a[FP32_W-1] != b[FP32_W-1]) begin
      a_gt_b = ~a[FP32_W-1];
    end else if (!a[FP32_W-1]) begin
      a_gt_b = (a[FP32_W-2:0] > b[FP32_W-2:0]);
    end else begin
      a_gt_b = (a[FP32_W-2:0] < b[FP32_W-2:0]);
    end
  end

endmodule

// File: rtl/softmax_max_sequencer.sv
// Softmax max-reduction sequencer: streams N FP32 logits from the logit
// buffer, folds them into a running maximum and offers the result to the
// subtract/exp stage with a valid/ready handshake.
// Optional feature macro: SOFTMAX_MAX_IDX_EN adds the max_idx (argmax) port.
module softmax_max_sequencer
  import softmax_pkg::*;
#(
  parameter int N      = 10,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [FP32_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SOFTMAX_MAX_IDX_EN
  output logic [ADDR_W-1:0] max_idx,
`endif
  output logic [FP32_W-1:0] max_val
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rdEnDly_q;
  logic [ADDR_W-1:0] rdIdxDly_q;
  logic [FP32_W-1:0] acc_q, acc_d;
  logic [FP32_W-1:0] maxVal_q, maxVal_d;
  logic              lastAddr;
  logic              newGt;
  logic              takeNew;
`ifdef SOFTMAX_MAX_IDX_EN
  logic [ADDR_W-1:0] accIdx_q, accIdx_d;
  logic [ADDR_W-1:0] maxIdx_q, maxIdx_d;
`endif

  assign lastAddr = (addr_q == LAST_ADDR);

  fp32_gt_cmp u_cmp (
    .a      (rd_data),
    .b      (acc_q),
    .a_gt_b (newGt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start outside IDLE is simply dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (lastAddr) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded directly from the registered state
  always_comb begin
    busy      = (state_q != IDLE);
    rd_en     = (state_q == FETCH);
    out_valid = (state_q == DONE);
    rd_addr   = addr_q;
  end

  // Read address walks 0..N-1 during FETCH and parks at 0 otherwise
  always_comb begin
    addr_d = '0;
    if (state_q == FETCH && !lastAddr) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Fold the returned word into the running max; element 0 always loads,
  // later elements only on strictly greater so the lowest index wins ties
  always_comb begin
    takeNew = rdEnDly_q && ((rdIdxDly_q == '0) || newGt);
    acc_d   = acc_q;
`ifdef SOFTMAX_MAX_IDX_EN
    accIdx_d = accIdx_q;
`endif
    if (takeNew) begin
      acc_d = rd_data;
`ifdef SOFTMAX_MAX_IDX_EN
      accIdx_d = rdIdxDly_q;
`endif
    end else if (state_q == IDLE && start) begin
      acc_d = FP32_NEG_INF;
`ifdef SOFTMAX_MAX_IDX_EN
      accIdx_d = '0;
`endif
    end
  end

  // Publish the final max in DRAIN, folding in the last word the same cycle
  always_comb begin
    maxVal_d = maxVal_q;
`ifdef SOFTMAX_MAX_IDX_EN
    maxIdx_d = maxIdx_q;
`endif
    if (state_q == DRAIN) begin
      maxVal_d = acc_d;
`ifdef SOFTMAX_MAX_IDX_EN
      maxIdx_d = accIdx_d;
`endif
    end
  end

  // Datapath registers: address counter, read-return tracking, max state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rdEnDly_q  <= 1'b0;
      rdIdxDly_q <= '0;
      acc_q      <= FP32_NEG_INF;
      maxVal_q   <= '0;
`ifdef SOFTMAX_MAX_IDX_EN
      accIdx_q   <= '0;
      maxIdx_q   <= '0;
`endif
    end else begin
      addr_q     <= addr_d;
      rdEnDly_q  <= rd_en;
      rdIdxDly_q <= addr_q;
      acc_q      <= acc_d;
      maxVal_q   <= maxVal_d;
`ifdef SOFTMAX_MAX_IDX_EN
      accIdx_q   <= accIdx_d;
      maxIdx_q   <= maxIdx_d;
`endif
    end
  end

  assign max_val = maxVal_q;
`ifdef SOFTMAX_MAX_IDX_EN
  assign max_idx = maxIdx_q;
`endif

endmodule
